serial_nibble_deserializer: RTL and testbench
=============================================

Name: serial_nibble_deserializer

Overview:
- Serial-in/parallel-out stage directly upstream of the team's 4-bit D register stage.
- Collects one bit per accepted cycle and assembles WIDTH-bit words.
- Presents each completed word on a valid/ready output whose data feeds the register stage's `d` input.
- Provides backpressure on the serial side so no bit is ever dropped.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in m_data[WIDTH-1]; 0 = first bit lands in m_data[0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of partial word and held output word.
- s_valid  input  1  serial bit valid.
- s_bit  input  1  serial data bit.
- s_ready  output  1  stage can accept s_bit this cycle.
- m_data  output  WIDTH  assembled word.
- m_valid  output  1  m_data holds a complete word.
- m_ready  input  1  downstream consumes word this cycle.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- One clock; reset is asynchronous and active-low; all state is cleared while rst_n=0.
- Reset values: m_data=0, m_valid=0, busy=0, bit count=0, shift register=0, FSM=IDLE. s_ready=1 after reset.
- Transfers:
  - Serial bit accepted on a rising edge when s_valid && s_ready.
  - Output word transferred when m_valid && m_ready.
- FSM states:
  - IDLE (count=0). An accepted bit moves to SHIFT with count=1.
  - SHIFT (1 ≤ count ≤ WIDTH-1). Each accepted bit increments count.
  - When the WIDTH-th bit is accepted: the full word (shift contents plus this bit) loads m_data, m_valid sets, count returns to 0, state returns to IDLE, all on that same edge.
- Latency: m_valid is high in the cycle immediately after the edge that accepted the last bit. Zero added bubble.
- Throughput: one word per WIDTH accepted bits, sustained with s_valid=1 and m_ready=1.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters at LSB; bit k of the stream (k=0 first) ends at m_data[WIDTH-1-k].
  - MSB_FIRST=0: shift right, new bit enters at MSB; bit k ends at m_data[k].
- s_ready = (count != WIDTH-1) || !m_valid || m_ready. Partial bits are always accepted; only the final bit of a word stalls while an un-drained word is held. s_ready is combinational from m_ready; there is no combinational path from s_valid.
- m_valid clears on handshake unless a new word completes on the same edge. Simultaneous completion and handshake: m_valid stays 1 and m_data updates to the new word.
- m_data is stable while m_valid=1 and m_ready=0. It holds its last value after consumption; it is not zeroed.
- s_valid=0 cycles (gaps) mid-word: count and shift register hold; no timeout.
- clear=1 at a rising edge: count=0, shift register=0, m_valid=0, FSM=IDLE. A bit presented in that cycle is discarded even if s_valid && s_ready. An output handshake in that cycle is still counted as consumed downstream, because m_data was valid. clear has priority over all other updates.
- rst_n asserted mid-word or with a word held: everything returns to reset values immediately (asynchronously); the partial word is lost.
- busy = (count != 0), registered-derived with no combinational inputs.

Decomposition:
- Shared package `serial_pkg`:
  - FSM state typedef (IDLE, SHIFT).
  - A function returning the next shift value given MSB_FIRST.
  - Localparam for the count width, $clog2(WIDTH).
- Sub-module `word_out_reg`: the WIDTH-bit valid/ready holding register (load, m_valid, m_data, handshake). It is reusable by later stages and is the element that interfaces to the downstream D register stage.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random s_valid/s_bit -> m_valid=0, m_data=0, busy=0, s_ready=1. Release, then send bits 1,0,1,1 (MSB_FIRST=1, m_ready=1) -> m_valid=1 for exactly one cycle with m_data=4'b1011, the cycle after the 4th bit's edge.
- LSB-first: MSB_FIRST=0, bits 1,0,1,1 -> m_data=4'b1101. Continuous stream of 1,1,0,0,0,1,0,1 with m_ready=1 -> words 4'b0011 then 4'b1010, back-to-back with no gap cycle.
- Backpressure (MSB_FIRST=1): m_ready=0, send 0,1,1,0 -> m_data=4'b0110 held. Send 1,1,1 -> accepted, busy=1. 4th bit: s_ready=0 and bit held off. Raise m_ready for one cycle -> handshake of 4'b0110 and acceptance of the 4th bit on the same edge; next cycle m_valid=1, m_data=4'b1111.
- Gaps: bits 1,0 then s_valid=0 for 5 cycles, then 0,1 -> busy=1 during the gap, single word 4'b1001.
- Clear mid-word: bits 1,1 then clear=1 with s_valid=1, s_bit=1 -> count 0, busy=0, m_valid=0, bit dropped. Next 0,0,0,1 -> m_data=4'b0001.
- Async reset mid-word: after bits 1,0,1, pulse rst_n low between clock edges -> outputs zero immediately, before the next clk edge. Next 4 bits form a fresh word with no residue.

Source files
------------

// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial-to-parallel deserializer:
//   - state_e   : deserializer FSM state (IDLE / SHIFT)
//   - MAX_WIDTH : largest supported word width
//   - CNT_W     : bit-count register width; sized for MAX_WIDTH, so it fits
//                 every legal WIDTH (2..16)
//   - shift_in  : next shift-register value for either bit ordering
// ----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int MAX_WIDTH = 16;
    localparam int CNT_W     = $clog2(MAX_WIDTH);

    // Operates on a MAX_WIDTH container. Only the low 'width' bits are
    // meaningful; everything above is forced to zero.
    //   msb_first=1: shift left, new bit enters at bit 0
    //   msb_first=0: shift right, new bit enters at bit width-1
    function automatic logic [MAX_WIDTH-1:0] shift_in(
        input logic [MAX_WIDTH-1:0] cur,
        input logic                 new_bit,
        input int unsigned          width,
        input logic                 msb_first
    );
        logic [MAX_WIDTH-1:0] r;
        logic [MAX_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < int'(width)) mask[i] = 1'b1;
        end
        if (msb_first) begin
            r = {cur[MAX_WIDTH-2:0], new_bit};
        end else begin
            r = (cur & mask) >> 1;
            r[width-1] = new_bit;
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/word_out_reg.sv
// ----------------------------------------------------------------------------
// word_out_reg
// WIDTH-bit valid/ready holding register. Feeds the downstream D register.
//   clk, rst_n    : clock, async active-low reset
//   clear_i       : synchronous drop of the held word (data itself is kept)
//   load_i        : capture load_data_i and raise valid_o
//   load_data_i   : word to capture
//   ready_i       : downstream consumes the word this cycle
//   valid_o       : data_o holds a complete word
//   data_o        : held word; stable while valid_o && !ready_i
//
// Handshake: a word moves downstream on any rising edge where
// valid_o && ready_i. The producer must only assert load_i when the register
// is empty or being drained on the same edge; a load on the draining edge
// keeps valid_o high with the new word.
// ----------------------------------------------------------------------------
module word_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/serial_nibble_deserializer.sv
// ----------------------------------------------------------------------------
// serial_nibble_deserializer
// Collects one serial bit per accepted cycle and presents each completed
// WIDTH-bit word on a valid/ready output.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous flush of partial word and held output word
//   s_valid    : serial bit valid
//   s_bit      : serial data bit
//   s_ready    : stage accepts s_bit this cycle
//   m_data     : assembled word
//   m_valid    : m_data holds a complete word
//   m_ready    : downstream consumes word this cycle
//   busy       : partial word in progress
// Parameters: WIDTH (2..16), MSB_FIRST (1: first bit -> m_data[WIDTH-1]).
// ----------------------------------------------------------------------------
module serial_nibble_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]     sr_q,    sr_d;
    logic [MAX_WIDTH-1:0] shifted;
    logic [WIDTH-1:0]     word_next;
    logic                 shift_bits_unused;
    logic                 last_bit;
    logic                 accept;
    logic                 load;
    logic                 m_valid_int;

    assign shifted           = shift_in(MAX_WIDTH'(sr_q), s_bit, WIDTH, MSB_FIRST);
    assign word_next         = shifted[WIDTH-1:0];
    assign shift_bits_unused = ^shifted;

    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

    // Only the closing bit of a word can stall: it needs the output register
    // to be empty or draining on the same edge.
    assign s_ready = !last_bit || !m_valid_int || m_ready;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        load    = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sr_d    = '0;
        end else if (accept) begin
            if (last_bit) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sr_d    = '0;
                load    = 1'b1;
            end else begin
                state_d = ST_SHIFT;
                cnt_d   = cnt_q + CNT_W'(1);
                sr_d    = word_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    word_out_reg #(
        .WIDTH (WIDTH)
    ) u_word_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .load_i      (load),
        .load_data_i (word_next),
        .ready_i     (m_ready),
        .valid_o     (m_valid_int),
        .data_o      (m_data)
    );

    assign m_valid = m_valid_int;
    assign busy    = (cnt_q != '0);

endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// ----------------------------------------------------------------------------
// tb_serial_nibble_deserializer
// Two instances (MSB-first and LSB-first) share one stimulus stream. A model
// tracks the received bit list and the held output word; a negedge process
// compares every output of both instances against it each cycle. Directed
// literal checks pin the model at the key points of each scenario.
// ----------------------------------------------------------------------------
module tb_serial_nibble_deserializer;

    localparam int W = 4;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         clear   = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_bit   = 1'b0;
    logic         m_ready = 1'b0;

    logic         s_ready_m, m_valid_m, busy_m;
    logic [W-1:0] m_data_m;
    logic         s_ready_l, m_valid_l, busy_l;
    logic [W-1:0] m_data_l;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    serial_nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .s_valid (s_valid),
        .s_bit   (s_bit),
        .s_ready (s_ready_m),
        .m_data  (m_data_m),
        .m_valid (m_valid_m),
        .m_ready (m_ready),
        .busy    (busy_m)
    );

    serial_nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .s_valid (s_valid),
        .s_bit   (s_bit),
        .s_ready (s_ready_l),
        .m_data  (m_data_l),
        .m_valid (m_valid_l),
        .m_ready (m_ready),
        .busy    (busy_l)
    );

    // ---------------- model ----------------
    logic         mdl_bits[$];
    logic         mdl_valid = 1'b0;
    logic [W-1:0] mdl_msb   = '0;
    logic [W-1:0] mdl_lsb   = '0;

    function automatic logic mdl_s_ready();
        return (mdl_bits.size() != W - 1) || !mdl_valid || m_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_bits.delete();
            mdl_valid = 1'b0;
            mdl_msb   = '0;
            mdl_lsb   = '0;
        end else if (clear) begin
            mdl_bits.delete();
            mdl_valid = 1'b0;
        end else begin
            logic acc;
            acc = s_valid && mdl_s_ready();
            if (mdl_valid && m_ready) mdl_valid = 1'b0;
            if (acc) begin
                mdl_bits.push_back(s_bit);
                if (mdl_bits.size() == W) begin
                    for (int k = 0; k < W; k++) begin
                        mdl_msb[W-1-k] = mdl_bits[k];
                        mdl_lsb[k]     = mdl_bits[k];
                    end
                    mdl_valid = 1'b1;
                    mdl_bits.delete();
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model s_ready msb", 16'(s_ready_m), 16'(mdl_s_ready()));
        cmp("model s_ready lsb", 16'(s_ready_l), 16'(mdl_s_ready()));
        cmp("model m_valid msb", 16'(m_valid_m), 16'(mdl_valid));
        cmp("model m_valid lsb", 16'(m_valid_l), 16'(mdl_valid));
        cmp("model m_data msb",  16'(m_data_m),  16'(mdl_msb));
        cmp("model m_data lsb",  16'(m_data_l),  16'(mdl_lsb));
        cmp("model busy msb",    16'(busy_m),    16'(mdl_bits.size() != 0));
        cmp("model busy lsb",    16'(busy_l),    16'(mdl_bits.size() != 0));
    end

    // ---------------- driver ----------------
    // Presents one bit and returns 1ns after the edge that accepted it.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_bit   = b;
        @(negedge clk);
        while (!s_ready_m && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready_m) begin
            checks++;
            errors++;
            $display("FAIL send_bit timeout: s_ready got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] bits_first_at_msb, input int count);
        logic [3:0] v;
        v = bits_first_at_msb;
        for (int i = 0; i < count; i++) send_bit(v[3-i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset with random serial activity
        rst_n   = 1'b0;
        m_ready = 1'b1;
        repeat (3) begin
            step();
            s_valid = 1'($urandom_range(0, 1));
            s_bit   = 1'($urandom_range(0, 1));
        end
        cmp("rst m_valid",  16'(m_valid_m), 16'h0);
        cmp("rst m_data m", 16'(m_data_m),  16'h0);
        cmp("rst m_data l", 16'(m_data_l),  16'h0);
        cmp("rst busy",     16'(busy_m),    16'h0);
        cmp("rst s_ready",  16'(s_ready_m), 16'h1);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        step();

        // First word: 1,0,1,1
        send_nib(4'b1011, 4);
        cmp("w1 m_valid",  16'(m_valid_m), 16'h1);
        cmp("w1 m_data m", 16'(m_data_m),  16'hB);
        cmp("w1 m_data l", 16'(m_data_l),  16'hD);
        step();
        cmp("w1 one cycle", 16'(m_valid_m), 16'h0);

        // Continuous stream 1,1,0,0,0,1,0,1
        send_nib(4'b1100, 4);
        cmp("s1 m_data m", 16'(m_data_m), 16'hC);
        cmp("s1 m_data l", 16'(m_data_l), 16'h3);
        send_nib(4'b0101, 4);
        cmp("s2 m_valid",  16'(m_valid_l), 16'h1);
        cmp("s2 m_data m", 16'(m_data_m),  16'h5);
        cmp("s2 m_data l", 16'(m_data_l),  16'hA);
        step();

        // Backpressure
        m_ready = 1'b0;
        send_nib(4'b0110, 4);
        cmp("bp held m", 16'(m_data_m), 16'h6);
        cmp("bp held l", 16'(m_data_l), 16'h6);
        send_nib(4'b1110, 3);
        cmp("bp busy",   16'(busy_m),    16'h1);
        cmp("bp valid",  16'(m_valid_m), 16'h1);
        cmp("bp stable", 16'(m_data_m),  16'h6);
        s_valid = 1'b1;
        s_bit   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            cmp("bp stall s_ready", 16'(s_ready_m), 16'h0);
        end
        step();
        m_ready = 1'b1;
        @(negedge clk);
        cmp("bp release s_ready", 16'(s_ready_m), 16'h1);
        step();
        m_ready = 1'b0;
        s_valid = 1'b0;
        cmp("bp new valid",  16'(m_valid_m), 16'h1);
        cmp("bp new data m", 16'(m_data_m),  16'hF);
        cmp("bp new data l", 16'(m_data_l),  16'hF);
        m_ready = 1'b1;
        step();

        // Gaps mid-word
        send_nib(4'b1000, 2);
        repeat (5) begin
            step();
            cmp("gap busy", 16'(busy_m), 16'h1);
        end
        send_nib(4'b0100, 2);
        cmp("gap m_data m", 16'(m_data_m), 16'h9);
        cmp("gap m_data l", 16'(m_data_l), 16'h9);

        // Clear mid-word, with a held word and a bit offered on the clear edge
        m_ready = 1'b0;
        send_nib(4'b1100, 2);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_bit   = 1'b1;
        step();
        clear   = 1'b0;
        s_valid = 1'b0;
        cmp("clr busy",  16'(busy_m),    16'h0);
        cmp("clr valid", 16'(m_valid_m), 16'h0);
        m_ready = 1'b1;
        send_nib(4'b0001, 4);
        cmp("clr m_data m", 16'(m_data_m), 16'h1);
        cmp("clr m_data l", 16'(m_data_l), 16'h8);
        step();

        // Async reset between edges
        send_nib(4'b1010, 3);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("arst busy",    16'(busy_m),    16'h0);
        cmp("arst valid",   16'(m_valid_m), 16'h0);
        cmp("arst m_data m", 16'(m_data_m), 16'h0);
        cmp("arst m_data l", 16'(m_data_l), 16'h0);
        cmp("arst s_ready", 16'(s_ready_m), 16'h1);
        #1;
        rst_n = 1'b1;
        step();
        send_nib(4'b0011, 4);
        cmp("post arst m", 16'(m_data_m), 16'h3);
        cmp("post arst l", 16'(m_data_l), 16'hC);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
